// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits.
// Two write-back ports, two combinational read ports and one issue port.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, reads forward
// same-cycle write data and mask the hazard for a register being written.
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wend0,
  input  logic            wend1,
  input  logic [AW-1:0]   write_adr0,
  input  logic [AW-1:0]   write_adr1,
  input  logic [XLEN-1:0] write_data0,
  input  logic [XLEN-1:0] write_data1,
  input  logic [AW-1:0]   read_adr1,
  input  logic [AW-1:0]   read_adr2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            hazard1,
  output logic            hazard2,
  output logic [AW:0]     pending_cnt,
  output logic            wb_err
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;
  logic             err_nxt;
  logic             we0;
  logic             we1;
  logic             claim0;
  logic             claim1;

  // Register 0 is hard-wired: writes to it are dropped before anything else sees them.
  assign we0 = wend0 && (write_adr0 != '0);
  assign we1 = wend1 && (write_adr1 != '0);

  // A same-cycle issue to the written register counts as a claim.
  assign claim0 = pending[write_adr0] || (issue_en && (issue_rd == write_adr0));
  assign claim1 = pending[write_adr1] || (issue_en && (issue_rd == write_adr1));

  // Next pending vector: writes clear, issue sets, and issue wins over a write to the same register.
  always_comb begin
    pend_nxt = pending;
    cnt_nxt  = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if ((we0 && (write_adr0 == AW'(i))) || (we1 && (write_adr1 == AW'(i))))
        pend_nxt[i] = 1'b0;
      if (issue_en && (issue_rd == AW'(i)))
        pend_nxt[i] = 1'b1;
    end
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    err_nxt = wb_err
            | (we0 && !claim0)
            | (we1 && !claim1)
            | (we0 && we1 && (write_adr0 == write_adr1));
  end

  // Storage: port 1 is applied last so it wins on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      if (we0) mem[write_adr0] <= write_data0;
      if (we1) mem[write_adr1] <= write_data1;
    end
  end

  // Scoreboard state; the count is registered from the next-state vector so it tracks pending exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      pending     <= pend_nxt;
      pending_cnt <= cnt_nxt;
      wb_err      <= err_nxt;
    end
  end

  // Combinational read ports; outputs are forced quiet while reset is held.
  always_comb begin
    read_data1 = mem[read_adr1];
    read_data2 = mem[read_adr2];
    hazard1    = (read_adr1 != '0) && pending[read_adr1];
    hazard2    = (read_adr2 != '0) && pending[read_adr2];
`ifdef REGFILE_BYPASS_EN
    if (we0 && (write_adr0 == read_adr1)) begin
      read_data1 = write_data0;
      hazard1    = 1'b0;
    end
    if (we1 && (write_adr1 == read_adr1)) begin
      read_data1 = write_data1;
      hazard1    = 1'b0;
    end
    if (we0 && (write_adr0 == read_adr2)) begin
      read_data2 = write_data0;
      hazard2    = 1'b0;
    end
    if (we1 && (write_adr1 == read_adr2)) begin
      read_data2 = write_data1;
      hazard2    = 1'b0;
    end
`endif
    if (rst) begin
      read_data1 = '0;
      read_data2 = '0;
      hazard1    = 1'b0;
      hazard2    = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard (XLEN=32, NREGS=32).
// Expected values for same-cycle reads depend on REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_en = 1'b0;
  logic [AW-1:0]   issue_rd = '0;
  logic            wend0 = 1'b0;
  logic            wend1 = 1'b0;
  logic [AW-1:0]   write_adr0 = '0;
  logic [AW-1:0]   write_adr1 = '0;
  logic [XLEN-1:0] write_data0 = '0;
  logic [XLEN-1:0] write_data1 = '0;
  logic [AW-1:0]   read_adr1 = '0;
  logic [AW-1:0]   read_adr2 = '0;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            hazard1;
  logic            hazard2;
  logic [AW:0]     pending_cnt;
  logic            wb_err;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_rd(issue_rd),
    .wend0(wend0), .wend1(wend1), .write_adr0(write_adr0), .write_adr1(write_adr1),
    .write_data0(write_data0), .write_data1(write_data1),
    .read_adr1(read_adr1), .read_adr2(read_adr2),
    .read_data1(read_data1), .read_data2(read_data2),
    .hazard1(hazard1), .hazard2(hazard2),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0;
    wend0 = 1'b0;
    wend1 = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    // inputs active while reset is held must have no effect
    rst = 1'b1;
    issue_en = 1'b1; issue_rd = 5'd9;
    wend0 = 1'b1; write_adr0 = 5'd9; write_data0 = 32'h0000_00AA;
    tick(); tick();
    for (int a = 0; a < 32; a++) begin
      read_adr1 = 5'(a); read_adr2 = 5'(a);
      #1;
      checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL reset_rd1[%0d]: got %h want 0", a, read_data1); end
      checks++; if (read_data2 !== 32'h0) begin failures++; $display("FAIL reset_rd2[%0d]: got %h want 0", a, read_data2); end
      checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin failures++; $display("FAIL reset_hz[%0d]: got %b%b want 00", a, hazard1, hazard2); end
    end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", wb_err); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
    read_adr1 = 5'd9;
    #1;
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL post_reset_cnt: got %0d want 0", pending_cnt); end
    checks++; if (read_data1 !== 32'h0 || hazard1 !== 1'b0) begin failures++; $display("FAIL post_reset_r9: got %h/%b want 0/0", read_data1, hazard1); end
  endtask

  task automatic test_issue_write();
    issue_en = 1'b1; issue_rd = 5'd5;
    tick();
    idle();
    read_adr1 = 5'd5;
    #1;
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL iw_hazard: got %b want 1", hazard1); end
    checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL iw_cnt1: got %0d want 1", pending_cnt); end
    wend0 = 1'b1; write_adr0 = 5'd5; write_data0 = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (read_data1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL iw_bypass_data: got %h want deadbeef", read_data1); end
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL iw_bypass_hz: got %b want 0", hazard1); end
`else
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL iw_nobypass_data: got %h want 0", read_data1); end
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL iw_nobypass_hz: got %b want 1", hazard1); end
`endif
    tick();
    idle();
    #1;
    checks++; if (read_data1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL iw_data: got %h want deadbeef", read_data1); end
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL iw_hz_after: got %b want 0", hazard1); end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL iw_cnt0: got %0d want 0", pending_cnt); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL iw_err: got %b want 0", wb_err); end
  endtask

  task automatic test_dual_write();
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    wend0 = 1'b1; write_adr0 = 5'd7; write_data0 = 32'h11;
    wend1 = 1'b1; write_adr1 = 5'd7; write_data1 = 32'h22;
    tick();
    idle();
    read_adr2 = 5'd7;
    #1;
    checks++; if (read_data2 !== 32'h22) begin failures++; $display("FAIL dual_data: got %h want 00000022", read_data2); end
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL dual_err: got %b want 1", wb_err); end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL dual_cnt: got %0d want 0", pending_cnt); end
    tick();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL dual_err_sticky: got %b want 1", wb_err); end
    pulse_reset();
    checks++; if (wb_err !== 1'b0 || read_data2 !== 32'h0) begin failures++; $display("FAIL dual_reset: got %b/%h want 0/0", wb_err, read_data2); end
  endtask

  task automatic test_reg0();
    issue_en = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd0;
    wend0 = 1'b1; write_adr0 = 5'd0; write_data0 = 32'hFFFF_FFFF;
    read_adr1 = 5'd0;
    #1;
    checks++; if (read_data1 !== 32'h0 || hazard1 !== 1'b0) begin failures++; $display("FAIL r0_same: got %h/%b want 0/0", read_data1, hazard1); end
    tick();
    idle();
    #1;
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL r0_data: got %h want 0", read_data1); end
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL r0_hz: got %b want 0", hazard1); end
    checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL r0_cnt: got %0d want 1", pending_cnt); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL r0_err: got %b want 0", wb_err); end
  endtask

  task automatic test_issue_and_write_same();
    issue_en = 1'b1; issue_rd = 5'd3;
    tick();
    checks++; if (pending_cnt !== 6'd2) begin failures++; $display("FAIL iws_cnt_before: got %0d want 2", pending_cnt); end
    wend1 = 1'b1; write_adr1 = 5'd3; write_data1 = 32'h33;
    read_adr1 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL iws_same_hz: got %b want 0", hazard1); end
`else
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL iws_same_hz: got %b want 1", hazard1); end
`endif
    tick();
    idle();
    #1;
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL iws_hz: got %b want 1", hazard1); end
    checks++; if (pending_cnt !== 6'd2) begin failures++; $display("FAIL iws_cnt: got %0d want 2", pending_cnt); end
    checks++; if (read_data1 !== 32'h33) begin failures++; $display("FAIL iws_data: got %h want 00000033", read_data1); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL iws_err: got %b want 0", wb_err); end
  endtask

  task automatic test_back_to_back();
    // retire both outstanding producers in one cycle on different ports
    wend0 = 1'b1; write_adr0 = 5'd4; write_data0 = 32'hA4A4_A4A4;
    wend1 = 1'b1; write_adr1 = 5'd3; write_data1 = 32'hB3B3_B3B3;
    tick();
    idle();
    read_adr1 = 5'd4; read_adr2 = 5'd3;
    #1;
    checks++; if (read_data1 !== 32'hA4A4_A4A4) begin failures++; $display("FAIL b2b_r4: got %h want a4a4a4a4", read_data1); end
    checks++; if (read_data2 !== 32'hB3B3_B3B3) begin failures++; $display("FAIL b2b_r3: got %h want b3b3b3b3", read_data2); end
    checks++; if (pending_cnt !== 6'd0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin failures++; $display("FAIL b2b_state: got cnt=%0d hz=%b%b want 0 00", pending_cnt, hazard1, hazard2); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b want 0", wb_err); end
    // write to a register nobody claimed
    wend0 = 1'b1; write_adr0 = 5'd10; write_data0 = 32'h1;
    tick();
    idle();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL unclaimed_err: got %b want 1", wb_err); end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    issue_en = 1'b1; issue_rd = 5'd2;
    tick();
    idle();
    wend0 = 1'b1; write_adr0 = 5'd2; write_data0 = 32'h55;
    tick();
    idle();
    read_adr1 = 5'd2;
    #1;
    checks++; if (read_data1 !== 32'h55) begin failures++; $display("FAIL mid_pre_data: got %h want 00000055", read_data1); end
    for (int r = 1; r <= 20; r++) begin
      issue_en = 1'b1; issue_rd = 5'(r);
      tick();
    end
    checks++; if (pending_cnt !== 6'd20) begin failures++; $display("FAIL mid_cnt20: got %0d want 20", pending_cnt); end
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL mid_hz: got %b want 1", hazard1); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL mid_cnt0: got %0d want 0", pending_cnt); end
    for (int a = 0; a < 32; a++) begin
      read_adr1 = 5'(a); read_adr2 = 5'(31 - a);
      #1;
      checks++; if (read_data1 !== 32'h0 || read_data2 !== 32'h0 || hazard1 !== 1'b0 || hazard2 !== 1'b0)
        begin failures++; $display("FAIL mid_read[%0d]: got %h %h %b%b want 0 0 00", a, read_data1, read_data2, hazard1, hazard2); end
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL mid_after: got %0d want 0", pending_cnt); end
  endtask

  initial begin
    test_reset();
    test_issue_write();
    test_dual_write();
    test_reg0();
    test_issue_and_write_same();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port issue_en  in  1  an instruction claiming issue_rd is issued this cycle.
REQ-006 SHALL have port issue_rd  in  AW  destination register being claimed.
REQ-007 SHALL have ports wend0, wend1  in  1  write enables, write-back ports 0 and 1.
REQ-008 SHALL have ports write_adr0, write_adr1  in  AW  write addresses.
REQ-009 SHALL have ports write_data0, write_data1  in  XLEN  write data.
REQ-010 SHALL have ports read_adr1, read_adr2  in  AW  read addresses.
REQ-011 SHALL have ports read_data1, read_data2  out  XLEN  combinational read data.
REQ-012 SHALL have ports hazard1, hazard2  out  1  addressed register has an outstanding producer.
REQ-013 SHALL have port pending_cnt  out  AW+1  number of registers currently pending.
REQ-014 SHALL have port wb_err  out  1  sticky error: illegal write-back seen.

Function
REQ-015 Register 0 SHALL read as zero, ignore writes and never become pending.
REQ-016 A write with wendN=1 and write_adrN!=0 SHALL update the register at the next rising clk edge.
REQ-017 If both ports write the same address in one cycle, port 1 data SHALL be stored.
REQ-018 issue_en=1 with issue_rd!=0 SHALL set pending[issue_rd] at the next edge.
REQ-019 A write to address a!=0 SHALL clear pending[a] at the next edge.
REQ-020 Issue and write to the same register in one cycle SHALL leave pending set (new producer wins).
REQ-021 hazardK SHALL be 1 iff read_adrK!=0, pending[read_adrK]=1 and the register is not being written this cycle (see REQ-030/031).
REQ-022 pending_cnt SHALL equal the population count of pending[] as registered, updated one cycle after the causing event.
REQ-023 wb_err SHALL set at the next edge if a write targets a!=0 with pending[a]=0 and no same-cycle... (a write without a claim), or if both ports write the same a!=0 in one cycle.
REQ-024 wb_err SHALL stay set until reset.
REQ-025 Reads SHALL have zero latency; state changes (registers, pending, pending_cnt, wb_err) one-cycle latency.

Reset
REQ-026 While rst=1 all registers SHALL be 0, pending[] all 0, pending_cnt=0, wb_err=0, regardless of clk.
REQ-027 read_data1/2 SHALL be 0 and hazard1/2 SHALL be 0 during reset.
REQ-028 Issue/write inputs asserted in the cycle rst deasserts SHALL be ignored until the first clk edge with rst=0.
REQ-029 Reset asserted mid-operation SHALL discard all pending claims and stored data immediately.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, read_dataK SHALL return same-cycle write data when read_adrK matches an active write (port 1 over port 0), and hazardK SHALL be 0 in that case.
REQ-031 Without REGFILE_BYPASS_EN, read_dataK SHALL return stored contents only, and hazardK SHALL follow pending[read_adrK] unmasked by same-cycle writes.

Verification
REQ-032 Reset, then read all addresses -> read_data=0, hazard=0, pending_cnt=0, wb_err=0.
REQ-033 issue_rd=5; next cycle read_adr1=5 -> hazard1=1, pending_cnt=1; wend0, adr 5, data 0xDEADBEEF -> with bypass read_data1=0xDEADBEEF and hazard1=0 same cycle; without bypass both next cycle; pending_cnt=0 after.
REQ-034 wend0 and wend1 both to reg 7 (pending) with 0x11 / 0x22 -> reg7=0x22, wb_err=1.
REQ-035 Write 0xFFFFFFFF to reg 0 and issue_rd=0 -> read_data1=0, hazard1=0, pending_cnt unchanged, wb_err=0.
REQ-036 Pending reg 3; same cycle issue_rd=3 and wend1 to 3 -> pending[3] stays 1, hazard next cycle=1, pending_cnt unchanged.
REQ-037 Issue regs 1..31 then assert rst mid-sequence -> pending_cnt=0, all reads 0 immediately.
